cnn_frame_feeder: RTL

Input-side stage placed directly upstream of the CNN top. It accepts a raw 28×28 8-bit grayscale image over a valid/ready stream and stores it in one of two ping-pong frame banks. It then replays each complete frame to the CNN as 784 back-to-back `data_in`/`valid_in` beats. A new frame starts only when the CNN is idle, and a bank is released only when the CNN reports its decision, so a second image can load while the first is being classified.

---
 rtl/cnn_feeder_pkg.sv | 20 ++
 rtl/frame_bank_ram.sv | 33 +++
 rtl/cnn_frame_feeder.sv | 135 +++++++++++++
 3 files changed

// File: rtl/cnn_feeder_pkg.sv
// cnn_feeder_pkg
// Shared definitions for the CNN frame feeder: frame size helper, default
// geometry and the reader FSM state encoding.
package cnn_feeder_pkg;

    function automatic int frame_pixels(input int width, input int height);
        return width * height;
    endfunction

    localparam int DEF_IMG_WIDTH  = 28;
    localparam int DEF_IMG_HEIGHT = 28;
    localparam int FRAME_PIXELS   = frame_pixels(DEF_IMG_WIDTH, DEF_IMG_HEIGHT);

    typedef enum logic [1:0] {
        R_IDLE      = 2'd0,
        R_STREAM    = 2'd1,
        R_WAIT_DONE = 2'd2
    } rd_state_e;

endpackage

// File: rtl/frame_bank_ram.sv
// frame_bank_ram
// Two frame banks in one simple dual-port array, addressed as {bank, pixel}.
// Ports:
//   clk_i            clock
//   we_i/waddr_i/wdata_i   write port
//   re_i/raddr_i     read request; rdata_o is valid the cycle after re_i
// The array has no reset; contents are only meaningful once written.
module frame_bank_ram #(
    parameter int PIX_BITS  = 8,
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [ADDR_BITS:0]   waddr_i,
    input  logic [PIX_BITS-1:0]  wdata_i,
    input  logic                 re_i,
    input  logic [ADDR_BITS:0]   raddr_i,
    output logic [PIX_BITS-1:0]  rdata_o
);
    // Bank bit is the address MSB, so each bank occupies a full 2^ADDR_BITS span.
    localparam int DEPTH = 2 ** (ADDR_BITS + 1);

    logic [PIX_BITS-1:0] mem_q [DEPTH];
    logic [PIX_BITS-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/cnn_frame_feeder.sv
// cnn_frame_feeder
// Loads 28x28 grayscale frames from a valid/ready stream into two ping-pong
// banks and replays each complete frame to the CNN as back-to-back beats.
// Ports:
//   clk, rst_n (sync, active-low), flush (sync abort, same as reset)
//   s_data/s_valid/s_ready   pixel input stream, row-major
//   m_data/m_valid           pixel output to CNN data_in/valid_in
//   cnn_busy, cnn_done       CNN status; done releases the streamed bank
//   frame_cnt                acknowledged frames, wraps at 256
//   busy                     any bank full, writer mid-frame, or reader active
module cnn_frame_feeder
    import cnn_feeder_pkg::*;
#(
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int PIX_BITS   = 8,
    parameter int ADDR_BITS  = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic [PIX_BITS-1:0] s_data,
    input  logic                s_valid,
    output logic                s_ready,
    output logic [PIX_BITS-1:0] m_data,
    output logic                m_valid,
    input  logic                cnn_busy,
    input  logic                cnn_done,
    output logic [7:0]          frame_cnt,
    output logic                busy
);
    localparam int N = frame_pixels(IMG_WIDTH, IMG_HEIGHT);
    localparam logic [ADDR_BITS-1:0] LAST = ADDR_BITS'(N - 1);

    logic                 clr;
    logic [1:0]           full_q, full_d;
    logic                 wr_bank_q;
    logic [ADDR_BITS-1:0] wr_addr_q;
    logic                 rd_bank_q;
    logic [ADDR_BITS-1:0] rd_addr_q;
    rd_state_e            rd_state_q;
    logic                 m_valid_q;
    logic [7:0]           frame_cnt_q;
    logic [PIX_BITS-1:0]  ram_rdata;
    logic                 wr_fire, wr_last, rd_issue, rd_release;

    assign clr        = !rst_n || flush;
    assign s_ready    = !full_q[wr_bank_q];
    assign wr_fire    = s_valid && s_ready;
    assign wr_last    = wr_fire && (wr_addr_q == LAST);
    assign rd_issue   = (rd_state_q == R_STREAM);
    assign rd_release = (rd_state_q == R_WAIT_DONE) && cnn_done;

    // Writer fills one bank while the reader releases the other; both
    // updates can land in the same cycle on different bits.
    always_comb begin
        full_d = full_q;
        if (wr_last)    full_d[wr_bank_q] = 1'b1;
        if (rd_release) full_d[rd_bank_q] = 1'b0;
    end

    // Writer: free-running address into the current non-full bank.
    always_ff @(posedge clk) begin
        if (clr) begin
            full_q    <= 2'b00;
            wr_bank_q <= 1'b0;
            wr_addr_q <= '0;
        end else begin
            full_q <= full_d;
            if (wr_fire) begin
                if (wr_last) begin
                    wr_addr_q <= '0;
                    wr_bank_q <= !wr_bank_q;
                end else begin
                    wr_addr_q <= wr_addr_q + 1'b1;
                end
            end
        end
    end

    // Reader FSM with registered output valid and frame counter.
    always_ff @(posedge clk) begin
        if (clr) begin
            rd_state_q  <= R_IDLE;
            rd_bank_q   <= 1'b0;
            rd_addr_q   <= '0;
            m_valid_q   <= 1'b0;
            frame_cnt_q <= 8'd0;
        end else begin
            // Read data comes back one cycle after issue, so valid tracks it.
            m_valid_q <= rd_issue;
            case (rd_state_q)
                R_IDLE: begin
                    if (full_q[rd_bank_q] && !cnn_busy) begin
                        rd_addr_q  <= '0;
                        rd_state_q <= R_STREAM;
                    end
                end
                R_STREAM: begin
                    rd_addr_q <= rd_addr_q + 1'b1;
                    if (rd_addr_q == LAST) rd_state_q <= R_WAIT_DONE;
                end
                R_WAIT_DONE: begin
                    if (cnn_done) begin
                        rd_bank_q   <= !rd_bank_q;
                        frame_cnt_q <= frame_cnt_q + 8'd1;
                        rd_state_q  <= R_IDLE;
                    end
                end
                default: rd_state_q <= R_IDLE;
            endcase
        end
    end

    frame_bank_ram #(
        .PIX_BITS (PIX_BITS),
        .ADDR_BITS(ADDR_BITS)
    ) u_ram (
        .clk_i  (clk),
        .we_i   (wr_fire),
        .waddr_i({wr_bank_q, wr_addr_q}),
        .wdata_i(s_data),
        .re_i   (rd_issue),
        .raddr_i({rd_bank_q, rd_addr_q}),
        .rdata_o(ram_rdata)
    );

    // The RAM output register carries no reset; hold the bus at zero
    // whenever no beat is being presented.
    assign m_data    = m_valid_q ? ram_rdata : '0;
    assign m_valid   = m_valid_q;
    assign frame_cnt = frame_cnt_q;
    assign busy      = (|full_q) || (wr_addr_q != '0) || (rd_state_q != R_IDLE);

endmodule
